// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg : shared constants, FSM state type and saturating increment
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] FWD_NONE = 2'b00;
  localparam logic [1:0] FWD_WB   = 2'b01;
  localparam logic [1:0] FWD_MEM  = 2'b10;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    LU_STALL = 1'b1
  } lu_state_t;

  // Increment v, clamping at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v >= top) ? top : v + 64'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fwd_select.sv
// -----------------------------------------------------------------------------
// fwd_select : EX operand forward select for one source register
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  output logic [1:0]        sel
);

  logic mem_hit;
  logic wb_hit;

  // A load still in MEM has no data yet, so it can never be a forward source.
  assign mem_hit = mem_regwrite & ~mem_memread & (mem_rd != '0) & (mem_rd == src);
  assign wb_hit  = wb_regwrite & (wb_rd != '0) & (wb_rd == src);

  always_comb begin
    sel = FWD_NONE;
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
  end

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit : EX forwarding, WB->ID bypass, load-use stall FSM, counters
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int LOAD_STALL = 1,
  parameter int WB_BYPASS  = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_memread,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_regwrite,
  input  logic              mem_memread,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_regwrite,
  input  logic              hold,
  input  logic              flush,
  input  logic              cnt_clr,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              id_byp_a,
  output logic              id_byp_b,
  output logic              stall,
  output logic              bubble_ex,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  fwd_cnt
);

  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic       lu_hit;
  logic       stall_now;
  lu_state_t  state;
  logic [2:0] bcnt;

  fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .src(ex_rs), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_a)
  );

  fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .src(ex_rt), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_b)
  );

  assign fwd_a = rst_n ? sel_a : FWD_NONE;
  assign fwd_b = rst_n ? sel_b : FWD_NONE;

  generate
    if (WB_BYPASS != 0) begin : g_byp
      logic wb_valid;
      assign wb_valid = rst_n & wb_regwrite & (wb_rd != '0);
      assign id_byp_a = wb_valid & id_use_rs & (wb_rd == id_rs);
      assign id_byp_b = wb_valid & id_use_rt & (wb_rd == id_rt);
    end else begin : g_no_byp
      assign id_byp_a = 1'b0;
      assign id_byp_b = 1'b0;
    end
  endgenerate

  assign lu_hit = ex_memread & ex_regwrite & (ex_rd != '0) &
                  ((id_use_rs & (ex_rd == id_rs)) | (id_use_rt & (ex_rd == id_rt)));

  // The first bubble is raised combinationally in IDLE; LU_STALL covers the rest.
  assign stall_now = rst_n & ~flush & ((state == LU_STALL) | lu_hit);
  assign stall     = stall_now;
  assign bubble_ex = stall_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bcnt  <= '0;
    end else if (flush) begin
      state <= IDLE;
      bcnt  <= '0;
    end else if (!hold) begin
      case (state)
        IDLE: begin
          if (lu_hit && (LOAD_STALL > 1)) begin
            state <= LU_STALL;
            bcnt  <= 3'(LOAD_STALL - 1);
          end
        end
        LU_STALL: begin
          if (bcnt == 3'd1) begin
            state <= IDLE;
            bcnt  <= '0;
          end else begin
            bcnt <= bcnt - 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          bcnt  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else if (!hold) begin
      if (stall_now)
        stall_cnt <= CNT_W'(sat_inc(64'(stall_cnt), CNT_W));
      if ((fwd_a != FWD_NONE) || (fwd_b != FWD_NONE))
        fwd_cnt <= CNT_W'(sat_inc(64'(fwd_cnt), CNT_W));
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit : directed bench, one-bubble and three-bubble instances
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_hazard_fwd_unit;

  logic       clk, rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_use_rs, id_use_rt, ex_regwrite, ex_memread;
  logic       mem_regwrite, mem_memread, wb_regwrite, hold, flush, cnt_clr;

  logic [1:0]  fa1, fb1, fa3, fb3;
  logic        ba1, bb1, ba3, bb3, st1, bu1, st3, bu3;
  logic [15:0] sc1, fc1;
  logic [3:0]  sc3, fc3;

  int errors = 0;
  int checks = 0;

  hazard_fwd_unit #(.REG_AW(5), .LOAD_STALL(1), .WB_BYPASS(1), .CNT_W(16)) u1 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .hold(hold), .flush(flush), .cnt_clr(cnt_clr),
    .fwd_a(fa1), .fwd_b(fb1), .id_byp_a(ba1), .id_byp_b(bb1),
    .stall(st1), .bubble_ex(bu1), .stall_cnt(sc1), .fwd_cnt(fc1)
  );

  hazard_fwd_unit #(.REG_AW(5), .LOAD_STALL(3), .WB_BYPASS(0), .CNT_W(4)) u3 (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_memread(mem_memread),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .hold(hold), .flush(flush), .cnt_clr(cnt_clr),
    .fwd_a(fa3), .fwd_b(fb3), .id_byp_a(ba3), .id_byp_b(bb3),
    .stall(st3), .bubble_ex(bu3), .stall_cnt(sc3), .fwd_cnt(fc3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clr_inputs();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
    ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
    mem_rd = 0; mem_regwrite = 0; mem_memread = 0;
    wb_rd = 0; wb_regwrite = 0; hold = 0; flush = 0; cnt_clr = 0;
  endtask

  task automatic hazard();
    ex_memread = 1; ex_regwrite = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
  endtask

  task automatic clr_counters();
    tick(); cnt_clr = 1;
    tick(); cnt_clr = 0;
  endtask

  logic hold_v [6] = '{0, 1, 1, 0, 0, 0};
  logic stall_v[6] = '{1, 1, 1, 1, 1, 0};

  initial begin
    clr_inputs();
    rst_n = 0;
    #3;
    chk("reset_stall", st3, 0);
    chk("reset_stall_cnt", sc1, 0);
    chk("reset_fwd_cnt", fc3, 0);
    chk("reset_fwd_a", fa1, 0);
    tick(); rst_n = 1;

    // forwarding priority and qualifiers
    tick(); mem_rd = 3; wb_rd = 3; ex_rs = 3; ex_rt = 3; mem_regwrite = 1; wb_regwrite = 1;
    #1 chk("mem_wins_a", fa1, 2); chk("mem_wins_b", fb1, 2); chk("mem_wins_a_u3", fa3, 2);
    tick(); mem_regwrite = 0;
    #1 chk("wb_only_a", fa1, 1); chk("wb_only_b", fb1, 1);
    tick(); mem_regwrite = 1; mem_memread = 1;
    #1 chk("mem_load_no_fwd_a", fa1, 1); chk("mem_load_no_fwd_b", fb1, 1);
    tick(); mem_memread = 0; mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
    #1 chk("reg0_a", fa1, 0); chk("reg0_b", fb1, 0);
    tick(); ex_rs = 3; ex_rt = 4; mem_rd = 4; wb_rd = 3;
    #1 chk("split_a", fa1, 1); chk("split_b", fb1, 2);
    tick(); wb_rd = 7; id_rs = 7; id_use_rs = 1; id_rt = 7; id_use_rt = 0;
    #1 chk("byp_a", ba1, 1); chk("byp_b_unused", bb1, 0); chk("byp_disabled", ba3, 0);

    // clear has priority while the forward condition is still active
    tick(); cnt_clr = 1;
    tick(); cnt_clr = 0; clr_inputs();
    #1 chk("clr_prio_u1", fc1, 0); chk("clr_prio_u3", fc3, 0);

    // single-bubble load-use
    tick(); hazard();
    #1 chk("ls1_stall", st1, 1); chk("ls1_bubble", bu1, 1);
    tick(); clr_inputs(); ex_rt = 5; wb_rd = 5; wb_regwrite = 1;
    #1 chk("ls1_release", st1, 0); chk("ls1_fwd_b", fb1, 1); chk("ls1_stall_cnt", sc1, 1);
    tick(); clr_inputs();
    tick(); tick();
    clr_counters();

    // three-bubble load-use with a two-cycle hold in the middle
    for (int i = 0; i < 6; i++) begin
      tick(); clr_inputs();
      if (i == 0) hazard();
      hold = hold_v[i];
      #1 chk($sformatf("ls3_hold_c%0d", i), st3, stall_v[i]);
      if (i == 2) chk("ls3_cnt_frozen", sc3, 1);
    end
    chk("ls3_stall_cnt", sc3, 3);
    clr_counters();

    // flush in the second stall cycle
    tick(); hazard();
    #1 chk("fl_c1", st3, 1);
    tick(); clr_inputs(); flush = 1;
    #1 chk("fl_c2_stall", st3, 0); chk("fl_c2_bubble", bu3, 0);
    tick(); flush = 0;
    #1 chk("fl_c3_idle", st3, 0); chk("fl_stall_cnt", sc3, 1);
    // flush coinciding with lu_hit
    tick(); hazard(); flush = 1;
    #1 chk("fl_lu_same", st3, 0);
    tick(); clr_inputs();
    #1 chk("fl_lu_next", st3, 0); chk("fl_lu_cnt", sc3, 1);
    // flush overrides hold
    tick(); hazard();
    #1 chk("flh_c1", st3, 1);
    tick(); clr_inputs(); hold = 1; flush = 1;
    #1 chk("flh_c2", st3, 0);
    tick(); hold = 0; flush = 0;
    #1 chk("flh_c3", st3, 0); chk("flh_cnt", sc3, 2);
    clr_counters();

    // saturation: 2^4+4 cycles on the 4-bit instance
    tick(); mem_rd = 3; ex_rs = 3; mem_regwrite = 1;
    repeat (20) tick();
    clr_inputs();
    #1 chk("sat_u3", fc3, 15); chk("nosat_u1", fc1, 20);
    tick(); cnt_clr = 1;
    tick(); cnt_clr = 0;
    #1 chk("clr_u3", fc3, 0); chk("clr_u1", fc1, 0);
    tick(); mem_rd = 3; ex_rs = 3; mem_regwrite = 1; hold = 1;
    repeat (3) tick();
    clr_inputs();
    #1 chk("hold_no_inc", fc1, 0);

    // async reset in the middle of LU_STALL
    tick(); hazard();
    #1 chk("rst_pre_c1", st3, 1);
    tick(); clr_inputs();
    #1 chk("rst_pre_c2", st3, 1);
    rst_n = 0;
    #1 chk("rst_async_stall", st3, 0); chk("rst_async_bubble", bu3, 0); chk("rst_async_cnt", sc3, 0);
    tick(); rst_n = 1;
    #1 chk("rst_after_idle", st3, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised successor to the two-operand EX-stage forwarding logic of the 5-stage MIPS pipeline.
- Combines the following in one block:
  - MEM/WB to EX forwarding selects with corrected, symmetric priority.
  - Optional WB to ID register-file bypass.
  - Load-use hazard detection with a configurable multi-cycle stall FSM.
  - Saturating performance counters.
- Sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and drives the PC/IF-ID write enables and the ID/EX bubble insert.

Parameters:
- REG_AW, 5, register address width (register 0 is hardwired zero and is never a hazard).
- LOAD_STALL, 1, bubbles inserted per load-use hazard (1..7).
- WB_BYPASS, 1, 1 = generate the ID-stage write-through selects; 0 = tie them to 0.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock
- rst_n  in  1  asynchronous active-low reset
- id_rs, id_rt  in  REG_AW  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs / rt
- ex_rs, ex_rt, ex_rd  in  REG_AW  EX-stage sources and destination
- ex_regwrite, ex_memread  in  1  EX-stage control
- mem_rd  in  REG_AW  MEM-stage destination
- mem_regwrite, mem_memread  in  1  MEM-stage control
- wb_rd  in  REG_AW  WB-stage destination
- wb_regwrite  in  1  WB-stage control
- hold  in  1  external global freeze (e.g. cache miss)
- flush  in  1  branch taken / redirect; squashes ID
- cnt_clr  in  1  synchronous clear of both counters
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM
- id_byp_a, id_byp_b  out  1  ID operand takes the WB write data
- stall  out  1  freeze PC and IF/ID
- bubble_ex  out  1  zero ID/EX control (insert nop)
- stall_cnt  out  CNT_W  cycles with stall=1 due to load-use
- fwd_cnt  out  CNT_W  cycles with fwd_a or fwd_b nonzero

Behaviour:
- Reset (rst_n low, async):
  - State IDLE, bubble counter 0, stall_cnt and fwd_cnt 0.
  - stall, bubble_ex, fwd_a, fwd_b, id_byp_a, id_byp_b forced 0 while rst_n is low.
- Forward select, per operand x in {rs, rt}, combinational, zero latency:
  - MEM match = mem_regwrite & !mem_memread & mem_rd!=0 & mem_rd==ex_x.
  - WB match = wb_regwrite & wb_rd!=0 & wb_rd==ex_x.
  - Output 10 on MEM match, else 01 on WB match, else 00.
  - MEM always beats WB, identically for fwd_a and fwd_b.
- ID bypass: id_byp_x = WB_BYPASS & wb_regwrite & wb_rd!=0 & wb_rd==id_x & id_use_x.
- Load-use detect (lu_hit, combinational): ex_memread & ex_regwrite & ex_rd!=0 & ((id_use_rs & ex_rd==id_rs) | (id_use_rt & ex_rd==id_rt)).
- FSM states: IDLE, LU_STALL.
  - IDLE: stall = bubble_ex = lu_hit & !flush. On such a cycle with !hold: if LOAD_STALL>1, load counter with LOAD_STALL-1 and go to LU_STALL; else stay IDLE.
  - LU_STALL: stall = bubble_ex = 1. Each non-hold cycle the counter decrements. When the counter is 1 at the clock edge, return to IDLE.
  - Total bubbles per hazard = LOAD_STALL exactly.
- hold=1: state and counter frozen; outputs keep their current values; counters do not increment.
- flush=1: overrides everything. stall=bubble_ex=0 that cycle, the FSM goes to IDLE, and the counter is cleared. This also applies with hold=1 and when flush and lu_hit coincide.
- lu_hit re-firing inside LU_STALL is ignored (EX holds a bubble).
- Counters:
  - Each increments by 1 per non-hold cycle when its condition is true and saturates at all-ones.
  - cnt_clr has priority over increment.
  - Counters are not cleared by flush.

Decomposition:
- Package hazard_pkg holds:
  - FWD_NONE=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - The FSM state enum (IDLE, LU_STALL).
  - A saturating-increment function.
- Sub-module fwd_select:
  - Inputs: one source register plus the MEM/WB fields.
  - Output: a 2-bit select.
  - Instantiated twice (rs, rt).

Test Plan:
- mem_rd=wb_rd=ex_rs=ex_rt=3, both regwrite=1, mem_memread=0 -> fwd_a=fwd_b=10.
- Same stimulus with mem_regwrite=0 -> both 01. Same stimulus with reg 0 -> both 00.
- LOAD_STALL=1: ex_memread=1, ex_rd=5, id_rt=5, id_use_rt=1 -> stall=bubble_ex=1 for exactly 1 cycle. Next cycle (with wb_rd=5) -> fwd_b=01; stall_cnt=1.
- LOAD_STALL=3: same hazard -> stall high 3 consecutive cycles. Asserting hold for 2 cycles mid-sequence -> 5 cycles total; stall_cnt=3.
- LOAD_STALL=3: flush in the 2nd stall cycle -> stall drops that cycle, FSM returns to IDLE, and stall_cnt=1.
- Drive the fwd_cnt condition 2^CNT_W+4 cycles -> fwd_cnt stays all-ones. Pulse cnt_clr -> 0 next cycle. Drop rst_n mid-LU_STALL -> stall=0 immediately.
